// File: rtl/xadc_sample_frontend.sv
// rtl/xadc_sample_frontend.sv - XADC DRP sampler producing signed centred samples
//
// Issues one DRP read of DRP_ADDR per sample_tick and turns the unipolar
// 12-bit conversion result into a signed two's-complement sample.
// Optional feature macro: DC_TRACK_EN (adaptive DC removal instead of a
// fixed midpoint subtraction).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sample_tick  one-cycle sample request
//   drdy_in      XADC drdy_out
//   do_in        XADC do_out, conversion result in [15:4]
//   den_out      XADC den_in, one-cycle pulse per read
//   daddr_out    XADC daddr_in, constant DRP_ADDR
//   sample_out   signed centred sample, held between updates
//   sample_valid one-cycle strobe, sample_out updated this cycle
//   clip         one-cycle strobe with sample_valid when raw code is near a rail
//   timeout_err  sticky, drdy never arrived for a read
//   overrun      sticky, a tick was dropped while a read was in flight
module xadc_sample_frontend #(
    parameter logic [6:0] DRP_ADDR    = 7'h1F,
    parameter int         TIMEOUT     = 64,
    parameter int         CLIP_MARGIN = 16,
    parameter int         DC_SHIFT    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic        den_out,
    output logic [6:0]  daddr_out,
    output logic [11:0] sample_out,
    output logic        sample_valid,
    output logic        clip,
    output logic        timeout_err,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, CONV} state_t;

    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [11:0] CLIP_LO   = 12'(CLIP_MARGIN);
    localparam logic [11:0] CLIP_HI   = 12'(4095 - CLIP_MARGIN);

    state_t      state, state_next;
    logic [7:0]  wait_cnt;
    logic [11:0] raw;
    logic [11:0] centred;
    logic        raw_clipped;

    // Low nibble of the DRP word carries no conversion data.
    logic unused_lsbs;
    assign unused_lsbs = ^do_in[3:0];

    assign daddr_out   = DRP_ADDR;
    assign den_out     = (state == REQ);
    assign raw_clipped = (raw <= CLIP_LO) || (raw >= CLIP_HI);

`ifdef DC_TRACK_EN
    localparam int ACC_W = 12 + DC_SHIFT;
    // Tracker starts at mid-scale so the first sample matches the fixed-offset build.
    localparam logic [ACC_W-1:0] ACC_INIT = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [11:0]        dc;
    logic signed [12:0] diff;

    assign dc   = acc[ACC_W-1:DC_SHIFT];
    assign diff = $signed({1'b0, raw}) - $signed({1'b0, dc});
    // dc never exceeds acc>>DC_SHIFT, so the modular sum cannot wrap below zero.
    assign acc_next = acc + ACC_W'(raw) - ACC_W'(dc);

    always_comb begin
        centred = diff[11:0];
        if (diff > 13'sd2047) begin
            centred = 12'h7FF;
        end else if (diff < -13'sd2048) begin
            centred = 12'h800;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= ACC_INIT;
        end else if (state == CONV) begin
            acc <= acc_next;
        end
    end
`else
    // Time constant only matters to the DC tracker.
    localparam int UNUSED_DC_SHIFT = DC_SHIFT;

    // raw - 12'h800 is just the MSB flipped.
    assign centred = {~raw[11], raw[10:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (sample_tick) state_next = REQ;
            REQ:  state_next = WAIT;
            WAIT: begin
                if (drdy_in) begin
                    state_next = CONV;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = IDLE;
                end
            end
            CONV:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt     <= 8'd0;
            raw          <= 12'd0;
            sample_out   <= 12'd0;
            sample_valid <= 1'b0;
            clip         <= 1'b0;
            timeout_err  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            clip         <= 1'b0;
            case (state)
                REQ: wait_cnt <= 8'd0;
                WAIT: begin
                    if (drdy_in) begin
                        raw <= do_in[15:4];
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                CONV: begin
                    sample_out   <= centred;
                    sample_valid <= 1'b1;
                    clip         <= raw_clipped;
                end
                default: ;
            endcase
            // Includes the CONV cycle: the FSM only accepts ticks while in IDLE.
            if (sample_tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xadc_sample_frontend.sv
// tb/tb_xadc_sample_frontend.sv - scoreboard bench for xadc_sample_frontend
module tb_xadc_sample_frontend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick;
    logic        drdy_in;
    logic [15:0] do_in;
    logic        den_out;
    logic [6:0]  daddr_out;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic        clip;
    logic        timeout_err;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    int den_cnt   = 0;
    int valid_cnt = 0;
    logic [12:0] exp_q[$];
    logic [21:0] m_acc = 22'h200000;

    xadc_sample_frontend dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .drdy_in      (drdy_in),
        .do_in        (do_in),
        .den_out      (den_out),
        .daddr_out    (daddr_out),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .clip         (clip),
        .timeout_err  (timeout_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected {clip, sample} for a raw code; updates the tracker model in order.
    function automatic logic [12:0] model(input logic [11:0] r);
        logic       c;
        logic [11:0] s;
        int          diff;
        c = (r <= 12'd16) || (r >= 12'd4079);
`ifdef DC_TRACK_EN
        diff = int'(r) - int'(m_acc[21:10]);
        m_acc = m_acc + 22'(r) - 22'(m_acc[21:10]);
        if (diff > 2047) diff = 2047;
        if (diff < -2048) diff = -2048;
        s = 12'(diff);
`else
        diff = 0;
        s = r ^ 12'h800;
`endif
        return {c, s};
    endfunction

    always @(negedge clk) begin
        if (den_out) den_cnt++;
        if (sample_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("sample", {19'd0, clip, sample_out}, {19'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic pulse_reset(input int cycles);
        rst_n = 1'b0;
        m_acc = 22'h200000;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic tick_once();
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
    endtask

    // Tick, then drdy dly cycles after the den cycle; checks den and valid timing.
    task automatic do_read(input int dly, input logic [15:0] d);
        tick_once();
        chk("den_req", den_out, 1);
        repeat (dly) @(posedge clk);
        #1 drdy_in = 1'b1;
        do_in = d;
        exp_q.push_back(model(d[15:4]));
        @(posedge clk); #1 drdy_in = 1'b0;
        do_in = 16'h5A5A;
        @(posedge clk); #1 chk("valid_lat", sample_valid, 1);
        @(posedge clk); #1 chk("valid_one_cycle", sample_valid, 0);
    endtask

    initial begin
        int v0, d0;
        logic [15:0] pat[6];
        pat = '{16'hFFF0, 16'h0000, 16'h0100, 16'h0110, 16'hFEF0, 16'hFEE0};
        sample_tick = 1'b0;
        drdy_in = 1'b0;
        do_in = 16'h0000;
        pulse_reset(3);
        chk("rst_den", den_out, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_clip", clip, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("daddr", daddr_out, 7'h1F);

        // Nominal read
        do_read(3, 16'hC000);
        chk("nominal_sample", sample_out, 12'h400);
        chk("nominal_den_cnt", den_cnt, 1);
        chk("nominal_valid_cnt", valid_cnt, 1);

        // Full scale and clip-margin edges
        for (int i = 0; i < 6; i++) begin
            do_read(1 + (i % 3), pat[i]);
        end

        // Timeout, then a normal read with the flag staying set
        v0 = valid_cnt;
        tick_once();
        repeat (64) @(posedge clk);
        #1 chk("timeout_not_yet", timeout_err, 0);
        @(posedge clk); #1 chk("timeout_set", timeout_err, 1);
        chk("timeout_no_valid", valid_cnt - v0, 0);
        do_read(2, 16'h8000);
        chk("timeout_sticky", timeout_err, 1);

        // Overrun: second tick while waiting
        v0 = valid_cnt; d0 = den_cnt;
        chk("overrun_clear", overrun, 0);
        tick_once();
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 drdy_in = 1'b1; do_in = 16'h4560;
        exp_q.push_back(model(12'h456));
        @(posedge clk); #1 drdy_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("overrun_set", overrun, 1);
        chk("overrun_one_valid", valid_cnt - v0, 1);
        chk("overrun_one_den", den_cnt - d0, 1);

        // Tick during CONV is dropped
        pulse_reset(1);
        chk("conv_overrun_clear", overrun, 0);
        d0 = den_cnt;
        tick_once();
        @(posedge clk); #1 drdy_in = 1'b1; do_in = 16'h2340;
        exp_q.push_back(model(12'h234));
        @(posedge clk); #1 drdy_in = 1'b0; sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        chk("conv_tick_valid", sample_valid, 1);
        chk("conv_tick_overrun", overrun, 1);
        repeat (4) @(posedge clk);
        #1 chk("conv_tick_den", den_cnt - d0, 1);

        // Reset mid-WAIT, then a late drdy
        v0 = valid_cnt; d0 = den_cnt;
        tick_once();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        m_acc = 22'h200000;
        #1;
        chk("midrst_sample", sample_out, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_timeout", timeout_err, 0);
        chk("midrst_den", den_out, 0);
        @(posedge clk); #1 rst_n = 1'b1; drdy_in = 1'b1; do_in = 16'hC000;
        @(posedge clk); #1 drdy_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("midrst_no_valid", valid_cnt - v0, 0);
        chk("midrst_den_cnt", den_cnt - d0, 1);
        chk("midrst_sample_held", sample_out, 0);
        do_read(1, 16'h7FF0);

`ifdef DC_TRACK_EN
        pulse_reset(2);
        do_read(1, 16'hA000);
        chk("dc_first", sample_out, 12'h200);
        for (int i = 1; i < 8192; i++) begin
            do_read(1, 16'hA000);
        end
        chk("dc_settled", (sample_out == 12'h000) || (sample_out == 12'h001) || (sample_out == 12'hFFF), 1);
`endif

        repeat (3) @(posedge clk);
        #1 chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
